// File: rtl/pcs_transmit_code_group.sv
// 1000BASE-X PCS transmit: turns GMII octets into one 8b/10b code-group per clock,
// inserting idle ordered sets, /S/ /T/ /R/ /V/ and tracking running disparity.
module pcs_transmit_code_group (
    input  logic       clock,
    input  logic       mr_main_reset,
    input  logic       tx_en,
    input  logic       tx_er,
    input  logic [7:0] txd,
    output logic [9:0] tx_code_group,
    output logic       tx_even,
    output logic       tx_disparity
);
    localparam int unsigned CG_W = 10;

    // Special code-groups, abcdei fghj, for RD- and RD+ entry disparity
    localparam logic [CG_W-1:0] K28_5_N = 10'b0011111010;
    localparam logic [CG_W-1:0] K28_5_P = 10'b1100000101;
    localparam logic [CG_W-1:0] D5_6    = 10'b1010010110;
    localparam logic [CG_W-1:0] D16_2_P = 10'b1001000101;
    localparam logic [CG_W-1:0] K27_7_N = 10'b1101101000;
    localparam logic [CG_W-1:0] K27_7_P = 10'b0010010111;
    localparam logic [CG_W-1:0] K29_7_N = 10'b1011101000;
    localparam logic [CG_W-1:0] K29_7_P = 10'b0100010111;
    localparam logic [CG_W-1:0] K23_7_N = 10'b1110101000;
    localparam logic [CG_W-1:0] K23_7_P = 10'b0001010111;
    localparam logic [CG_W-1:0] K30_7_N = 10'b0111101000;
    localparam logic [CG_W-1:0] K30_7_P = 10'b1000010111;

    typedef enum logic [2:0] {
        ST_IDLE_K,
        ST_IDLE_D,
        ST_DATA,
        ST_END_R1,
        ST_END_R2
    } state_t;

    state_t state;
    logic   force_idle;

    // 5b/6b sub-block: table holds the RD- form; RD+ complements unbalanced codes and D.7
    function automatic logic [5:0] enc_5b6b(input logic [4:0] x, input logic rd);
        logic [5:0] c;
        c = 6'b000000;
        case (x)
            5'd0:  c = 6'b100111;
            5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;
            5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;
            5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;
            5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;
            5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;
            5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;
            5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;
            5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;
            5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;
            5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            5'd31: c = 6'b101011;
        endcase
        if (rd && (($countones(c) != 3) || (x == 5'd7)))
            c = ~c;
        return c;
    endfunction

    // 3b/4b sub-block selected by the RD left after the 6b part; A7 avoids run-length-5 sequences
    function automatic logic [3:0] enc_3b4b(input logic [2:0] y, input logic [4:0] x, input logic rd);
        logic [3:0] c;
        logic       alt;
        alt = rd ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                 : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20));
        c = 4'b0000;
        case (y)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b1001;
            3'd2: c = 4'b0101;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b1010;
            3'd6: c = 4'b0110;
            3'd7: c = alt ? 4'b0111 : 4'b1110;
        endcase
        if (rd && (($countones(c) != 2) || (y == 3'd3)))
            c = ~c;
        return c;
    endfunction

    function automatic logic [CG_W-1:0] enc_data(input logic [7:0] d, input logic rd);
        logic [5:0] c6;
        logic       rd_mid;
        int         n6;
        c6     = enc_5b6b(d[4:0], rd);
        n6     = $countones(c6);
        rd_mid = (n6 > 3) ? 1'b1 : ((n6 < 3) ? 1'b0 : rd);
        return {c6, enc_3b4b(d[7:5], d[4:0], rd_mid)};
    endfunction

    // Pair a code-group with the running disparity it leaves behind
    function automatic logic [CG_W:0] emit(input logic [CG_W-1:0] cg, input logic rd);
        int n;
        n = $countones(cg);
        return {((n > 5) ? 1'b1 : ((n < 5) ? 1'b0 : rd)), cg};
    endfunction

    function automatic logic [CG_W-1:0] pick(input logic [CG_W-1:0] neg, input logic [CG_W-1:0] pos,
                                             input logic rd);
        return rd ? pos : neg;
    endfunction

    // Ordered-set sequencer; force_idle guarantees a K28.5 after reset and after every /R/
    always_ff @(posedge clock or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            state         <= ST_IDLE_K;
            force_idle    <= 1'b1;
            tx_code_group <= '0;
            tx_even       <= 1'b0;
            tx_disparity  <= 1'b0;
        end else begin
            tx_even <= ~tx_even;
            case (state)
                ST_IDLE_K: begin
                    force_idle <= 1'b0;
                    if (tx_en && !tx_er && !force_idle) begin
                        {tx_disparity, tx_code_group} <= emit(pick(K27_7_N, K27_7_P, tx_disparity), tx_disparity);
                        state <= ST_DATA;
                    end else begin
                        {tx_disparity, tx_code_group} <= emit(pick(K28_5_N, K28_5_P, tx_disparity), tx_disparity);
                        state <= ST_IDLE_D;
                    end
                end
                ST_IDLE_D: begin
                    // RD+ here means the K28.5 started at RD-, so /I2/ restores RD-
                    {tx_disparity, tx_code_group} <= emit(pick(D5_6, D16_2_P, tx_disparity), tx_disparity);
                    state <= ST_IDLE_K;
                end
                ST_DATA: begin
                    if (!tx_en) begin
                        {tx_disparity, tx_code_group} <= emit(pick(K29_7_N, K29_7_P, tx_disparity), tx_disparity);
                        state <= ST_END_R1;
                    end else if (tx_er) begin
                        {tx_disparity, tx_code_group} <= emit(pick(K30_7_N, K30_7_P, tx_disparity), tx_disparity);
                    end else begin
                        {tx_disparity, tx_code_group} <= emit(enc_data(txd, tx_disparity), tx_disparity);
                    end
                end
                ST_END_R1: begin
                    {tx_disparity, tx_code_group} <= emit(pick(K23_7_N, K23_7_P, tx_disparity), tx_disparity);
                    // tx_even still holds the previous slot, so low means this /R/ is even
                    if (!tx_even) begin
                        state <= ST_END_R2;
                    end else begin
                        state      <= ST_IDLE_K;
                        force_idle <= 1'b1;
                    end
                end
                ST_END_R2: begin
                    {tx_disparity, tx_code_group} <= emit(pick(K23_7_N, K23_7_P, tx_disparity), tx_disparity);
                    state      <= ST_IDLE_K;
                    force_idle <= 1'b1;
                end
                default: state <= ST_IDLE_K;
            endcase
        end
    end

endmodule

// File: tb/tb_pcs_transmit_code_group.sv
// Bench for pcs_transmit_code_group: vector table of idle/frame sequences plus
// an all-octets frame against an independent two-column 8b/10b model.
module tb_pcs_transmit_code_group;

    logic       clock;
    logic       mr_main_reset;
    logic       tx_en;
    logic       tx_er;
    logic [7:0] txd;
    logic [9:0] tx_code_group;
    logic       tx_even;
    logic       tx_disparity;

    pcs_transmit_code_group dut (
        .clock         (clock),
        .mr_main_reset (mr_main_reset),
        .tx_en         (tx_en),
        .tx_er         (tx_er),
        .txd           (txd),
        .tx_code_group (tx_code_group),
        .tx_even       (tx_even),
        .tx_disparity  (tx_disparity)
    );

    localparam logic [9:0] K28N  = 10'b0011111010;
    localparam logic [9:0] K28P  = 10'b1100000101;
    localparam logic [9:0] D56   = 10'b1010010110;
    localparam logic [9:0] D162P = 10'b1001000101;
    localparam logic [9:0] K27N  = 10'b1101101000;
    localparam logic [9:0] K27P  = 10'b0010010111;
    localparam logic [9:0] K29N  = 10'b1011101000;
    localparam logic [9:0] K29P  = 10'b0100010111;
    localparam logic [9:0] K23N  = 10'b1110101000;
    localparam logic [9:0] K23P  = 10'b0001010111;
    localparam logic [9:0] K30N  = 10'b0111101000;
    localparam logic [9:0] K30P  = 10'b1000010111;
    localparam logic [9:0] D216  = 10'b1010100110;
    localparam logic [9:0] D00N  = 10'b1001110100;
    localparam logic [9:0] D00P  = 10'b0110001011;
    localparam logic [9:0] D30N  = 10'b1100011011;
    localparam logic [9:0] D30P  = 10'b1100010100;

    typedef struct {
        logic       en;
        logic       er;
        logic [7:0] d;
        logic [9:0] code;
        logic       even;
        logic       rd;
    } vec_t;

    typedef struct {
        logic [9:0] code;
        logic       even;
        logic       rd;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference 8b/10b with explicit RD-/RD+ columns; returns {rd_after, code}
    function automatic logic [10:0] tb_enc(input logic [7:0] d, input logic rd);
        logic [11:0] t6;
        logic [7:0]  t4;
        logic [5:0]  c6;
        logic [3:0]  c4;
        logic        r;
        int          x;
        x = int'(d[4:0]);
        t6 = '0;
        case (d[4:0])
            5'd0:  t6 = {6'b100111, 6'b011000};
            5'd1:  t6 = {6'b011101, 6'b100010};
            5'd2:  t6 = {6'b101101, 6'b010010};
            5'd3:  t6 = {6'b110001, 6'b110001};
            5'd4:  t6 = {6'b110101, 6'b001010};
            5'd5:  t6 = {6'b101001, 6'b101001};
            5'd6:  t6 = {6'b011001, 6'b011001};
            5'd7:  t6 = {6'b111000, 6'b000111};
            5'd8:  t6 = {6'b111001, 6'b000110};
            5'd9:  t6 = {6'b100101, 6'b100101};
            5'd10: t6 = {6'b010101, 6'b010101};
            5'd11: t6 = {6'b110100, 6'b110100};
            5'd12: t6 = {6'b001101, 6'b001101};
            5'd13: t6 = {6'b101100, 6'b101100};
            5'd14: t6 = {6'b011100, 6'b011100};
            5'd15: t6 = {6'b010111, 6'b101000};
            5'd16: t6 = {6'b011011, 6'b100100};
            5'd17: t6 = {6'b100011, 6'b100011};
            5'd18: t6 = {6'b010011, 6'b010011};
            5'd19: t6 = {6'b110010, 6'b110010};
            5'd20: t6 = {6'b001011, 6'b001011};
            5'd21: t6 = {6'b101010, 6'b101010};
            5'd22: t6 = {6'b011010, 6'b011010};
            5'd23: t6 = {6'b111010, 6'b000101};
            5'd24: t6 = {6'b110011, 6'b001100};
            5'd25: t6 = {6'b100110, 6'b100110};
            5'd26: t6 = {6'b010110, 6'b010110};
            5'd27: t6 = {6'b110110, 6'b001001};
            5'd28: t6 = {6'b001110, 6'b001110};
            5'd29: t6 = {6'b101110, 6'b010001};
            5'd30: t6 = {6'b011110, 6'b100001};
            5'd31: t6 = {6'b101011, 6'b010100};
        endcase
        c6 = rd ? t6[5:0] : t6[11:6];
        r  = ($countones(c6) > 3) ? 1'b1 : (($countones(c6) < 3) ? 1'b0 : rd);
        t4 = '0;
        case (d[7:5])
            3'd0: t4 = {4'b1011, 4'b0100};
            3'd1: t4 = {4'b1001, 4'b1001};
            3'd2: t4 = {4'b0101, 4'b0101};
            3'd3: t4 = {4'b1100, 4'b0011};
            3'd4: t4 = {4'b1101, 4'b0010};
            3'd5: t4 = {4'b1010, 4'b1010};
            3'd6: t4 = {4'b0110, 4'b0110};
            3'd7: t4 = {4'b1110, 4'b0001};
        endcase
        if (d[7:5] == 3'd7 && ((!r && (x == 17 || x == 18 || x == 20)) ||
                               (r && (x == 11 || x == 13 || x == 14))))
            t4 = {4'b0111, 4'b1000};
        c4 = r ? t4[3:0] : t4[7:4];
        r  = ($countones(c4) > 2) ? 1'b1 : (($countones(c4) < 2) ? 1'b0 : r);
        return {r, c6, c4};
    endfunction

    task automatic cmp(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_out(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty got %b expected entry", name, tx_code_group);
        end else begin
            e = sb.pop_front();
            cmp({name, ".code"}, tx_code_group, e.code);
            cmp({name, ".even"}, 10'(tx_even), 10'(e.even));
            cmp({name, ".rd"}, 10'(tx_disparity), 10'(e.rd));
        end
    endtask

    task automatic step(input logic en, input logic er, input logic [7:0] d,
                        input logic [9:0] code, input logic ev, input logic rd, input string name);
        exp_t e;
        tx_en = en;
        tx_er = er;
        txd   = d;
        e.code = code;
        e.even = ev;
        e.rd   = rd;
        sb.push_back(e);
        @(posedge clock);
        #1;
        check_out(name);
    endtask

    function automatic void add(input logic en, input logic er, input logic [7:0] d,
                                input logic [9:0] code, input logic ev, input logic rd);
        vec_t v;
        v.en = en; v.er = er; v.d = d; v.code = code; v.even = ev; v.rd = rd;
        vt.push_back(v);
    endfunction

    initial begin
        logic       m_rd;
        logic       ev;
        logic [10:0] r;

        // Idle after reset, including tx_er without tx_en
        for (int i = 0; i < 4; i++) begin
            add(1'b0, 1'b0, 8'h00, K28N, 1'b1, 1'b1);
            add(1'b0, 1'b0, 8'h00, D162P, 1'b0, 1'b0);
        end
        add(1'b0, 1'b1, 8'hFF, K28N, 1'b1, 1'b1);
        add(1'b0, 1'b1, 8'hFF, D162P, 1'b0, 1'b0);
        // Frame with /T/ on an even slot
        add(1'b1, 1'b0, 8'h55, K27N, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'hD5, D216, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'hD5, D216, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'h00, D00N, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, K29N, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, K23N, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, K28N, 1'b1, 1'b1);
        add(1'b0, 1'b0, 8'h00, D162P, 1'b0, 1'b0);
        // Frame ending RD+ with /T/ on an odd slot, then /I1/
        add(1'b1, 1'b0, 8'h55, K27N, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'h03, D30N, 1'b0, 1'b1);
        add(1'b1, 1'b0, 8'h00, D00P, 1'b1, 1'b1);
        add(1'b0, 1'b0, 8'h00, K29P, 1'b0, 1'b1);
        add(1'b0, 1'b0, 8'h00, K23P, 1'b1, 1'b1);
        add(1'b0, 1'b0, 8'h00, K23P, 1'b0, 1'b1);
        add(1'b0, 1'b0, 8'h00, K28P, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, D56, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, K28N, 1'b1, 1'b1);
        add(1'b0, 1'b0, 8'h00, D162P, 1'b0, 1'b0);
        // tx_en rising during /I2/, /V/ at both RDs, tx_en held through /R/
        add(1'b0, 1'b0, 8'h00, K28N, 1'b1, 1'b1);
        add(1'b1, 1'b0, 8'hAA, D162P, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'h55, K27N, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'h03, D30N, 1'b0, 1'b1);
        add(1'b1, 1'b1, 8'h00, K30P, 1'b1, 1'b1);
        add(1'b1, 1'b0, 8'h03, D30P, 1'b0, 1'b0);
        add(1'b1, 1'b1, 8'h00, K30N, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, K29N, 1'b0, 1'b0);
        add(1'b1, 1'b1, 8'h00, K23N, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'h00, K23N, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'h55, K28N, 1'b1, 1'b1);
        add(1'b1, 1'b0, 8'h55, D162P, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'h55, K27N, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'hD5, D216, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, K29N, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, K23N, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, K28N, 1'b1, 1'b1);
        add(1'b0, 1'b0, 8'h00, D162P, 1'b0, 1'b0);

        mr_main_reset = 1'b1;
        tx_en = 1'b0;
        tx_er = 1'b0;
        txd   = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        cmp("reset.code", tx_code_group, 10'b0000000000);
        cmp("reset.even", 10'(tx_even), 10'd0);
        cmp("reset.rd", 10'(tx_disparity), 10'd0);
        mr_main_reset = 1'b0;

        for (int i = 0; i < vt.size(); i++)
            step(vt[i].en, vt[i].er, vt[i].d, vt[i].code, vt[i].even, vt[i].rd, $sformatf("vec%0d", i));

        // Every octet value in one frame against the reference encoder
        m_rd = 1'b0;
        ev   = 1'b1;
        step(1'b1, 1'b0, 8'h55, m_rd ? K27P : K27N, ev, m_rd, "frame_s");
        for (int i = 0; i < 256; i++) begin
            r  = tb_enc(8'(i), m_rd);
            ev = ~ev;
            step(1'b1, 1'b0, 8'(i), r[9:0], ev, r[10], $sformatf("frame_d%0d", i));
            m_rd = r[10];
        end
        ev = ~ev;
        step(1'b0, 1'b0, 8'h00, m_rd ? K29P : K29N, ev, m_rd, "frame_t");
        ev = ~ev;
        step(1'b0, 1'b0, 8'h00, m_rd ? K23P : K23N, ev, m_rd, "frame_r1");
        if (ev) begin
            ev = ~ev;
            step(1'b0, 1'b0, 8'h00, m_rd ? K23P : K23N, ev, m_rd, "frame_r2");
        end
        ev = ~ev;
        step(1'b0, 1'b0, 8'h00, m_rd ? K28P : K28N, ev, ~m_rd, "frame_k");
        ev = ~ev;
        step(1'b0, 1'b0, 8'h00, m_rd ? D56 : D162P, ev, 1'b0, "frame_i");

        // Reset in the middle of a frame
        step(1'b1, 1'b0, 8'h55, K27N, 1'b1, 1'b0, "mid_s");
        step(1'b1, 1'b0, 8'hD5, D216, 1'b0, 1'b0, "mid_d");
        #2;
        mr_main_reset = 1'b1;
        #1;
        cmp("midrst.code", tx_code_group, 10'b0000000000);
        cmp("midrst.even", 10'(tx_even), 10'd0);
        cmp("midrst.rd", 10'(tx_disparity), 10'd0);
        @(posedge clock);
        #1;
        cmp("midrst_hold.code", tx_code_group, 10'b0000000000);
        cmp("midrst_hold.even", 10'(tx_even), 10'd0);
        mr_main_reset = 1'b0;
        step(1'b0, 1'b0, 8'h00, K28N, 1'b1, 1'b1, "restart_k");
        step(1'b0, 1'b0, 8'h00, D162P, 1'b0, 1'b0, "restart_i");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
